arcade_input_ctrl: RTL and testbench

//  Parametrised player-input front end for arcade cores. It sits between hps_io and the game core.
//  - Decodes PS/2 key events into per-player button state.
//  - Merges this with the MiSTer joysticks and applies screen-rotation remapping.
//  - Generates fixed-width coin pulses from dedicated coin inputs.
//  - Replaces the ad-hoc per-core keyboard always-block; coin is no longer derived from start.

---
 rtl/arcade_input_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_arcade_input_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arcade_input_ctrl.sv
// Player-input front end for arcade cores: PS/2 key decode, joystick merge, rotation, coin pulses.
// Define ARCADE_INPUT_AUTOFIRE_EN to enable the per-player autofire divider.
module arcade_input_ctrl #(
  parameter int unsigned PLAYERS      = 2,
  parameter int unsigned COIN_PULSE   = 1200000,
  parameter int unsigned AUTOFIRE_DIV = 600000
) (
  input  logic        clk_sys_i,
  input  logic        reset_n_i,
  input  logic [10:0] ps2_key_i,
  input  logic [15:0] joystick_0_i,
  input  logic [15:0] joystick_1_i,
  input  logic [1:0]  rot_i,
  input  logic [1:0]  autofire_i,
  output logic [3:0]  p1_dir_o,
  output logic [3:0]  p2_dir_o,
  output logic [1:0]  fire_o,
  output logic [1:0]  start_o,
  output logic [1:0]  coin_o
);

  localparam int unsigned CntW = $clog2(COIN_PULSE + 1);

  localparam int unsigned KUp     = 0;
  localparam int unsigned KDown   = 1;
  localparam int unsigned KLeft   = 2;
  localparam int unsigned KRight  = 3;
  localparam int unsigned KSpace  = 4;
  localparam int unsigned KCtrl   = 5;
  localparam int unsigned KStart1 = 6;
  localparam int unsigned KCoin1  = 7;
  localparam int unsigned K2Up    = 8;
  localparam int unsigned K2Down  = 9;
  localparam int unsigned K2Left  = 10;
  localparam int unsigned K2Right = 11;
  localparam int unsigned K2Fire  = 12;
  localparam int unsigned KStart2 = 13;
  localparam int unsigned KCoin2  = 14;

  typedef enum logic {StIdle, StPulse} coin_st_e;

  logic            primed_q;
  logic            old_tog_q;
  logic            key_evt;
  logic [14:0]     key_q, key_d;
  logic [3:0]      p1_raw, p2_raw;
  logic [1:0]      fire_raw, start_raw, req_raw;
  logic [3:0]      p1_dir_q, p2_dir_q;
  logic [1:0]      fire_q, fire_d, start_q;
  logic [1:0]      req_q, req_prev_q, rise;
  coin_st_e        st_q [2];
  coin_st_e        st_d [2];
  logic [CntW-1:0] cnt_q [2];
  logic [CntW-1:0] cnt_d [2];

  // Direction vectors are {up, down, left, right}.
  function automatic logic [3:0] rotate(input logic [3:0] d, input logic [1:0] r);
    case (r)
      2'd1:    rotate = {d[1], d[0], d[2], d[3]};
      2'd2:    rotate = {d[0], d[1], d[3], d[2]};
      default: rotate = d;
    endcase
  endfunction

  // The first cycle after reset only samples the toggle bit, so a stale event is not replayed.
  assign key_evt = primed_q && (ps2_key_i[10] != old_tog_q);

  always_comb begin
    key_d = key_q;
    if (key_evt) begin
      case (ps2_key_i[7:0])
        8'h75:   key_d[KUp]     = ps2_key_i[9];
        8'h72:   key_d[KDown]   = ps2_key_i[9];
        8'h6B:   key_d[KLeft]   = ps2_key_i[9];
        8'h74:   key_d[KRight]  = ps2_key_i[9];
        8'h29:   key_d[KSpace]  = ps2_key_i[9];
        8'h14:   key_d[KCtrl]   = ps2_key_i[9];
        8'h05:   key_d[KStart1] = ps2_key_i[9];
        8'h2E:   key_d[KCoin1]  = ps2_key_i[9];
        8'h2D:   key_d[K2Up]    = ps2_key_i[9];
        8'h2B:   key_d[K2Down]  = ps2_key_i[9];
        8'h23:   key_d[K2Left]  = ps2_key_i[9];
        8'h34:   key_d[K2Right] = ps2_key_i[9];
        8'h1C:   key_d[K2Fire]  = ps2_key_i[9];
        8'h06:   key_d[KStart2] = ps2_key_i[9];
        8'h36:   key_d[KCoin2]  = ps2_key_i[9];
        default: ;
      endcase
    end
  end

  always_comb begin
    p1_raw = {key_q[KUp] | joystick_0_i[3], key_q[KDown] | joystick_0_i[2],
              key_q[KLeft] | joystick_0_i[1], key_q[KRight] | joystick_0_i[0]};
    p2_raw = {key_q[K2Up] | joystick_1_i[3], key_q[K2Down] | joystick_1_i[2],
              key_q[K2Left] | joystick_1_i[1], key_q[K2Right] | joystick_1_i[0]};
    fire_raw  = {key_q[K2Fire] | joystick_1_i[4],
                 key_q[KSpace] | key_q[KCtrl] | joystick_0_i[4]};
    start_raw = {key_q[KStart2] | joystick_0_i[6] | joystick_1_i[6],
                 key_q[KStart1] | joystick_0_i[5] | joystick_1_i[5]};
    req_raw   = {key_q[KCoin2] | joystick_1_i[7], key_q[KCoin1] | joystick_0_i[7]};
    // Single-player cabinet: every player-2 source drives player 1.
    if (PLAYERS == 1) begin
      p1_raw      = p1_raw | p2_raw;
      p2_raw      = '0;
      fire_raw    = {1'b0, fire_raw[0] | fire_raw[1]};
      req_raw     = {1'b0, req_raw[0] | req_raw[1]};
    end
  end

  assign rise = req_q & ~req_prev_q;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      st_d[i]  = st_q[i];
      cnt_d[i] = cnt_q[i];
      unique case (st_q[i])
        StIdle: begin
          if (rise[i]) begin
            st_d[i]  = StPulse;
            cnt_d[i] = CntW'(COIN_PULSE - 1);
          end
        end
        StPulse: begin
          if (cnt_q[i] == '0) st_d[i] = StIdle;
          else                cnt_d[i] = cnt_q[i] - CntW'(1);
        end
        default: st_d[i] = StIdle;
      endcase
    end
  end

`ifdef ARCADE_INPUT_AUTOFIRE_EN
  localparam int unsigned AfW = $clog2(AUTOFIRE_DIV + 1);

  logic [AfW-1:0] af_cnt_q [2];
  logic [AfW-1:0] af_cnt_d [2];
  logic [1:0]     af_on_q, af_on_d;
  logic           unused_bits;

  assign unused_bits = ^{ps2_key_i[8], joystick_0_i[15:8], joystick_1_i[15:8]};

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      fire_d[i]   = fire_raw[i];
      af_on_d[i]  = 1'b0;
      af_cnt_d[i] = '0;
      if (fire_raw[i] && autofire_i[i]) begin
        af_on_d[i] = 1'b1;
        if (!af_on_q[i]) begin
          fire_d[i] = 1'b1;
        end else if (af_cnt_q[i] == AfW'(AUTOFIRE_DIV - 1)) begin
          fire_d[i] = ~fire_q[i];
        end else begin
          fire_d[i]   = fire_q[i];
          af_cnt_d[i] = af_cnt_q[i] + AfW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_sys_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      af_on_q <= '0;
      for (int i = 0; i < 2; i++) af_cnt_q[i] <= '0;
    end else begin
      af_on_q <= af_on_d;
      for (int i = 0; i < 2; i++) af_cnt_q[i] <= af_cnt_d[i];
    end
  end
`else
  logic unused_bits;

  assign unused_bits = ^{ps2_key_i[8], joystick_0_i[15:8], joystick_1_i[15:8], autofire_i};
  assign fire_d      = fire_raw;
`endif

  always_ff @(posedge clk_sys_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      primed_q   <= 1'b0;
      old_tog_q  <= 1'b0;
      key_q      <= '0;
      p1_dir_q   <= '0;
      p2_dir_q   <= '0;
      fire_q     <= '0;
      start_q    <= '0;
      req_q      <= '0;
      req_prev_q <= '0;
      for (int i = 0; i < 2; i++) begin
        st_q[i]  <= StIdle;
        cnt_q[i] <= '0;
      end
    end else begin
      primed_q  <= 1'b1;
      old_tog_q <= ps2_key_i[10];
      key_q     <= key_d;
      p1_dir_q  <= rotate(p1_raw, rot_i);
      p2_dir_q  <= rotate(p2_raw, rot_i);
      fire_q    <= fire_d;
      start_q   <= start_raw;
      req_q     <= req_raw;
      // A request already high at reset release must fall before it can count as an edge.
      req_prev_q <= primed_q ? req_q : req_raw;
      for (int i = 0; i < 2; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign p1_dir_o = p1_dir_q;
  assign p2_dir_o = p2_dir_q;
  assign fire_o   = fire_q;
  assign start_o  = start_q;
  assign coin_o   = {st_q[1] == StPulse, st_q[0] == StPulse};

endmodule

// File: tb/tb_arcade_input_ctrl.sv
// Scoreboard bench for arcade_input_ctrl: a two-player and a one-player instance share stimulus.
module tb_arcade_input_ctrl;

  localparam int FP1 = 0, FP2 = 1, FFire = 2, FStart = 3, FCoin = 4;

  typedef struct {
    int         cyc;
    int         dut;
    int         fld;
    logic [3:0] val;
    string      name;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [10:0] ps2_key;
  logic [15:0] joystick_0, joystick_1;
  logic [1:0]  rot, autofire;
  logic [3:0]  d_p1, d_p2, s_p1, s_p2;
  logic [1:0]  d_fire, d_start, d_coin, s_fire, s_start, s_coin;
  logic        tog;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  exp_t keep_q[$];

  always #5 clk = ~clk;

  arcade_input_ctrl #(.PLAYERS(2), .COIN_PULSE(4), .AUTOFIRE_DIV(3)) u_dut (
    .clk_sys_i(clk), .reset_n_i(reset_n), .ps2_key_i(ps2_key),
    .joystick_0_i(joystick_0), .joystick_1_i(joystick_1), .rot_i(rot), .autofire_i(autofire),
    .p1_dir_o(d_p1), .p2_dir_o(d_p2), .fire_o(d_fire), .start_o(d_start), .coin_o(d_coin)
  );

  arcade_input_ctrl #(.PLAYERS(1), .COIN_PULSE(4), .AUTOFIRE_DIV(3)) u_dut1 (
    .clk_sys_i(clk), .reset_n_i(reset_n), .ps2_key_i(ps2_key),
    .joystick_0_i(joystick_0), .joystick_1_i(joystick_1), .rot_i(rot), .autofire_i(autofire),
    .p1_dir_o(s_p1), .p2_dir_o(s_p2), .fire_o(s_fire), .start_o(s_start), .coin_o(s_coin)
  );

  function automatic logic [3:0] act(input int dut, input int fld);
    logic [3:0] r;
    r = '0;
    case (fld)
      FP1:     r = (dut == 0) ? d_p1 : s_p1;
      FP2:     r = (dut == 0) ? d_p2 : s_p2;
      FFire:   r = {2'b00, (dut == 0) ? d_fire : s_fire};
      FStart:  r = {2'b00, (dut == 0) ? d_start : s_start};
      default: r = {2'b00, (dut == 0) ? d_coin : s_coin};
    endcase
    return r;
  endfunction

  // Expectation for the output sampled k falling edges from now (k=0: the coming one).
  task automatic exp_at(input int k, input int dut, input int fld, input logic [3:0] v,
                        input string nm);
    exp_t e;
    e.cyc  = cyc + k;
    e.dut  = dut;
    e.fld  = fld;
    e.val  = v;
    e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic exp_zero(input int k);
    for (int d = 0; d < 2; d++)
      for (int f = 0; f < 5; f++) exp_at(k, d, f, 4'h0, "reset_zero");
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic key(input logic pressed, input logic ext, input logic [7:0] code);
    tog     = ~tog;
    ps2_key = {tog, pressed, ext, code};
  endtask

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  // Monitor: compare every expectation that falls due on this falling edge.
  initial begin
    logic [3:0] got;
    forever begin
      @(negedge clk);
      keep_q.delete();
      foreach (exp_q[i]) begin
        if (exp_q[i].cyc == cyc) begin
          got    = act(exp_q[i].dut, exp_q[i].fld);
          checks = checks + 1;
          if (got !== exp_q[i].val) begin
            errors = errors + 1;
            $display("FAIL %s cyc=%0d dut=%0d got=%b want=%b", exp_q[i].name, cyc,
                     exp_q[i].dut, got, exp_q[i].val);
          end
        end else if (exp_q[i].cyc < cyc) begin
          checks = checks + 1;
          errors = errors + 1;
          $display("FAIL %s missed cyc=%0d", exp_q[i].name, exp_q[i].cyc);
        end else begin
          keep_q.push_back(exp_q[i]);
        end
      end
      exp_q = keep_q;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] af_pat;
    int          n;
    reset_n    = 1'b0;
    ps2_key    = 11'h3FF;
    joystick_0 = 16'hFFFF;
    joystick_1 = 16'hFFFF;
    rot        = 2'd1;
    autofire   = 2'b11;
    tog        = 1'b0;
    tick(2);
    exp_zero(0);
    exp_zero(1);
    tick(2);

    // Release with a pending-looking toggle: must not be taken as a key event.
    joystick_0 = '0;
    joystick_1 = '0;
    rot        = 2'd0;
    autofire   = 2'b00;
    tog        = 1'b1;
    ps2_key    = {1'b1, 1'b1, 1'b0, 8'h29};
    reset_n    = 1'b1;
    for (int k = 1; k <= 4; k++) exp_at(k, 0, FFire, 4'h0, "no_evt_after_reset");
    tick(4);

    // PS/2 decode
    key(1'b1, 1'b0, 8'h29);
    exp_at(1, 0, FFire, 4'h0, "space_lat1");
    exp_at(2, 0, FFire, 4'h1, "space_press");
    exp_at(3, 0, FFire, 4'h1, "space_hold");
    tick(3);
    key(1'b0, 1'b0, 8'h29);
    exp_at(1, 0, FFire, 4'h1, "space_rel_lat1");
    exp_at(2, 0, FFire, 4'h0, "space_release");
    tick(3);
    key(1'b1, 1'b0, 8'h14);
    exp_at(2, 0, FFire, 4'h1, "ctrl_press");
    tick(3);
    key(1'b0, 1'b0, 8'h14);
    exp_at(2, 0, FFire, 4'h0, "ctrl_release");
    tick(3);
    key(1'b1, 1'b1, 8'h75);
    exp_at(2, 0, FP1, 4'b1000, "ext_up");
    tick(3);
    key(1'b1, 1'b0, 8'h6B);
    exp_at(2, 0, FP1, 4'b1010, "keypad_left");
    tick(3);
    key(1'b0, 1'b1, 8'h75);
    exp_at(2, 0, FP1, 4'b0010, "up_release");
    tick(3);
    key(1'b0, 1'b0, 8'h6B);
    exp_at(2, 0, FP1, 4'b0000, "left_release");
    tick(3);
    key(1'b1, 1'b0, 8'h34);
    exp_at(2, 0, FP2, 4'b0001, "p2_key_right");
    exp_at(2, 1, FP1, 4'b0001, "p1only_key_right");
    exp_at(2, 1, FP2, 4'b0000, "p1only_p2_zero");
    tick(3);
    key(1'b0, 1'b0, 8'h34);
    exp_at(2, 0, FP2, 4'b0000, "p2_key_release");
    tick(3);
    key(1'b1, 1'b0, 8'h1A);
    exp_at(2, 0, FP1, 4'b0000, "unmapped_p1");
    exp_at(2, 0, FFire, 4'h0, "unmapped_fire");
    tick(3);
    key(1'b0, 1'b0, 8'h1A);
    tick(3);

    // Rotation on joystick directions
    joystick_0 = 16'h0008;
    rot        = 2'd1;
    exp_at(1, 0, FP1, 4'b0001, "rot_cw_up_to_right");
    tick(2);
    rot = 2'd2;
    exp_at(1, 0, FP1, 4'b0010, "rot_ccw_up_to_left");
    tick(2);
    rot = 2'd0;
    exp_at(1, 0, FP1, 4'b1000, "rot_none");
    tick(2);
    rot = 2'd3;
    exp_at(1, 0, FP1, 4'b1000, "rot_3_none");
    tick(2);
    joystick_0 = '0;
    joystick_1 = 16'h0002;
    rot        = 2'd1;
    exp_at(1, 0, FP2, 4'b1000, "rot_cw_p2_left_to_up");
    exp_at(1, 1, FP1, 4'b1000, "p1only_rot_merge");
    exp_at(1, 1, FP2, 4'b0000, "p1only_p2_dir_zero");
    tick(2);
    joystick_1 = 16'h0020;
    rot        = 2'd0;
    exp_at(1, 0, FStart, 4'h1, "start1_from_joy1");
    exp_at(1, 0, FP2, 4'h0, "p2_dir_clear");
    tick(2);
    joystick_1 = '0;
    exp_at(1, 0, FStart, 4'h0, "start_clear");
    tick(2);

    // Coin from key held 20 cycles: one 4-cycle pulse
    key(1'b1, 1'b0, 8'h2E);
    for (int k = 1; k <= 22; k++)
      exp_at(k, 0, FCoin, (k >= 3 && k <= 6) ? 4'h1 : 4'h0, "coin_key_held");
    tick(20);
    key(1'b0, 1'b0, 8'h2E);
    for (int k = 1; k <= 5; k++) exp_at(k, 0, FCoin, 4'h0, "coin_key_release");
    tick(5);

    // Re-press during pulse is ignored
    joystick_0 = 16'h0080;
    for (int k = 1; k <= 9; k++)
      exp_at(k, 0, FCoin, (k >= 2 && k <= 5) ? 4'h1 : 4'h0, "coin_repress_ignored");
    tick(1);
    joystick_0 = '0;
    tick(1);
    joystick_0 = 16'h0080;
    tick(1);
    joystick_0 = '0;
    tick(6);

    // Both channels together
    joystick_0 = 16'h0080;
    joystick_1 = 16'h0080;
    for (int k = 1; k <= 6; k++) begin
      exp_at(k, 0, FCoin, (k >= 2 && k <= 5) ? 4'h3 : 4'h0, "coin_both_aligned");
      exp_at(k, 1, FCoin, (k >= 2 && k <= 5) ? 4'h1 : 4'h0, "p1only_coin_merge");
    end
    tick(1);
    joystick_0 = '0;
    joystick_1 = '0;
    tick(7);

    // Reset mid-pulse with request still high
    joystick_0 = 16'h0080;
    tick(3);
    reset_n = 1'b0;
    exp_at(0, 0, FCoin, 4'h0, "coin_reset_midpulse");
    tick(1);
    reset_n = 1'b1;
    for (int k = 1; k <= 6; k++) exp_at(k, 0, FCoin, 4'h0, "coin_held_after_reset");
    tick(3);
    joystick_0 = '0;
    tick(2);
    joystick_0 = 16'h0080;
    exp_at(2, 0, FCoin, 4'h1, "coin_after_rearm");
    exp_at(6, 0, FCoin, 4'h0, "coin_after_rearm_end");
    tick(7);
    joystick_0 = '0;
    tick(2);

    // Single-player merge
    joystick_1 = 16'h0010;
    exp_at(1, 1, FFire, 4'h1, "p1only_joy1_fire");
    exp_at(1, 0, FFire, 4'h2, "p2_joy1_fire");
    tick(2);
    joystick_1 = 16'h0018;
    exp_at(1, 1, FP1, 4'b1000, "p1only_joy1_up");
    exp_at(1, 1, FP2, 4'b0000, "p1only_p2_still_zero");
    tick(2);
    joystick_1 = '0;
    key(1'b1, 1'b0, 8'h1C);
    exp_at(1, 1, FFire, 4'h0, "p1only_gap");
    exp_at(2, 1, FFire, 4'h1, "p1only_key_a");
    exp_at(2, 0, FFire, 4'h2, "p2_key_a");
    exp_at(2, 1, FP2, 4'h0, "p1only_p2_zero_key");
    tick(3);
    key(1'b0, 1'b0, 8'h1C);
    exp_at(2, 1, FFire, 4'h0, "p1only_key_a_rel");
    exp_at(2, 0, FFire, 4'h0, "p2_key_a_rel");
    tick(3);

    // Autofire on player 1, fire held 12 cycles
`ifdef ARCADE_INPUT_AUTOFIRE_EN
    af_pat = 12'b111000111000;
`else
    af_pat = 12'b111111111111;
`endif
    autofire   = 2'b01;
    joystick_0 = 16'h0010;
    for (int k = 1; k <= 12; k++) exp_at(k, 0, FFire, {3'b000, af_pat[12-k]}, "autofire_pattern");
    tick(12);
    joystick_0 = '0;
    exp_at(1, 0, FFire, 4'h0, "autofire_release");
    tick(3);

    n = 0;
    while (exp_q.size() > 0 && n < 50) begin
      tick(1);
      n++;
    end
    if (exp_q.size() > 0) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
